systolic_a_skew_feeder: RTL and testbench
=========================================

Name: systolic_a_skew_feeder

Overview:
- Upstream operand stage for the tpumac systolic array; drives the A inputs of the left column of MAC cells.
- Buffers a DIM x DIM signed 8-bit operand tile loaded row by row.
- On start, streams the tile with diagonal skew: array row i is delayed i cycles, so operands meet in the array in lockstep with B.
- Honors the same en stall semantics as tpumac.

Parameters:
BITS_AB, 8, width of one signed operand (matches tpumac Ain/Bin)
DIM, 8, array dimension: rows buffered and operands per row

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  global advance enable; low freezes streaming state and outputs
wr_en  in  1  load strobe for one buffer row
wr_row  in  $clog2(DIM)  row index for load
wr_data  in  DIM*BITS_AB  row payload; element k at bits [k*BITS_AB +: BITS_AB]
start  in  1  single-cycle request to stream the buffered tile
Aout  out  DIM*BITS_AB  skewed operands; slice i drives Ain of array row i
out_valid  out  1  high on every cycle Aout carries a stream step
busy  out  1  high from accepted start through last stream step
done  out  1  one-cycle pulse after the final step

Behaviour:
- Reset (async, rst=1): Aout=0, out_valid=0, busy=0, done=0, state=IDLE, step counter=0, all buffer entries cleared to 0. Reset mid-stream aborts immediately, with no done pulse.
- Loads:
  - When IDLE, wr_en writes buf[wr_row][*] = wr_data at the clock edge, independent of en.
  - wr_row >= DIM is ignored.
  - wr_en while busy is dropped and buffer contents are unchanged.
- States: IDLE, STREAM.
  - IDLE -> STREAM when start=1 and en=1. This sets busy=1 and t=0.
  - start while busy is ignored.
  - A load and start in the same IDLE cycle are both accepted; the new row is used because the first sample occurs on the following edge.
- STREAM, each edge with en=1:
  - Register Aout slice i = buf[i][t-i] when 0 <= t-i < DIM, else 0.
  - Set out_valid=1 and increment t.
  - Total 2*DIM-1 steps, t = 0..2*DIM-2.
  - Latency: first valid Aout appears one cycle after the accepted start edge.
- en=0 in STREAM:
  - t, Aout and busy are held.
  - out_valid is forced 0 for that cycle.
  - No step is consumed.
- Completion:
  - After the step with t=2*DIM-2 is registered, the next edge with en=1 clears Aout to 0, drops out_valid and busy, pulses done for one cycle, and returns to IDLE.
  - A new start is accepted on the cycle done is high.
- Arithmetic: values pass through unchanged, signed BITS_AB; no extension or saturation. Zero-fill slots are exactly 0.
- Buffer is not cleared by streaming; the same tile can be restreamed.

Optional Feature:
- Macro SKEW_FEEDER_OVERRUN_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err sets sticky on any wr_en or start while busy, or on wr_en with wr_row >= DIM.
  - err clears only on rst.
- Undefined: err port absent; those events are silently dropped as described above.

Test Plan:
- Reset and defaults: assert rst mid-stream -> next cycle Aout=0, out_valid=0, busy=0, done=0; restream after load returns fresh data.
- Basic skew (DIM=8):
  - Stimulus: load buf[i][k] = 8*i+k, then start.
  - Step t=0: only slice0=0.
  - Step t=1: slice0=1, slice1=8.
  - Step t=7: slice i = 8*i+(7-i) for all i.
  - Step t=14: only slice7=63.
  - out_valid high for exactly 15 cycles, then a done pulse.
- Signed passthrough: load row 3 with all -128 and row 5 with all 127 -> those exact values appear in slices 3 and 5 on their diagonal steps; sign is not altered.
- Stall: drop en for 3 cycles at t=4 -> Aout held, out_valid=0 during the stall, resumes at t=5; still 15 valid steps total.
- Contention:
  - wr_en on row 2 with value 0x55 while busy -> buf unchanged on restream.
  - start while busy -> no restart.
  - With macro defined -> err=1 and sticky until rst.
- Same-cycle load+start: write row 0 = 0x11 in the start cycle -> t=0 slice0 = 0x11.

Source files
------------

// File: rtl/systolic_a_skew_feeder.sv
// ----------------------------------------------------------------------------
// systolic_a_skew_feeder
//   Buffers a DIM x DIM tile of signed BITS_AB-bit operands, loaded one row at
//   a time, and streams it diagonally skewed into the A inputs of the left
//   column of the systolic array.
//   Array row i is fed with a delay of i cycles, so its operands meet the
//   B stream in lockstep.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset (clears buffer too)
//   en         global advance enable; low freezes streaming state/outputs
//   wr_en      row load strobe (accepted only while idle)
//   wr_row     row index for the load
//   wr_data    row payload, element k at [k*BITS_AB +: BITS_AB]
//   start      request to stream the buffered tile
//   Aout       skewed operands, slice i drives Ain of array row i
//   out_valid  Aout carries a stream step this cycle
//   busy       from accepted start through the last stream step
//   done       one-cycle pulse after the final step
//   err        (only with SKEW_FEEDER_OVERRUN_ERR_EN) sticky overrun flag
//
// Build option
//   SKEW_FEEDER_OVERRUN_ERR_EN : adds the sticky err output. It is set by
//   wr_en or start while busy, or by wr_en to a row index >= DIM.
// ----------------------------------------------------------------------------

// Per-lane operand select: lane i at step t takes element (t - i) of its row.
// When that element is outside the row, the lane outputs 0.
module systolic_a_skew_lane #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int LANE    = 0,
    parameter int TW      = 4
) (
    input  logic [DIM*BITS_AB-1:0] i_row,
    input  logic [TW-1:0]          i_t,
    output logic [BITS_AB-1:0]     o_elem
);
    always_comb begin
        o_elem = '0;
        for (int k = 0; k < DIM; k++) begin
            if (int'(i_t) == LANE + k)
                o_elem = i_row[k*BITS_AB +: BITS_AB];
        end
    end
endmodule

module systolic_a_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS_AB-1:0]  wr_data,
    input  logic                    start,
    output logic [DIM*BITS_AB-1:0]  Aout,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
    ,
    output logic                    err
`endif
);
    // t runs 0..2*DIM-2 for the data steps. The value 2*DIM-1 means
    // "all steps issued, the next enabled edge completes".
    localparam int              TW       = $clog2(2*DIM);
    localparam logic [TW-1:0]   T_END    = TW'(2*DIM - 1);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_STREAM = 1'b1;

    logic [0:0]                         r_state;
    logic [TW-1:0]                      r_t;
    logic [DIM-1:0][DIM*BITS_AB-1:0]    r_buf;
    logic [DIM-1:0][BITS_AB-1:0]        w_next;
    logic                               w_row_ok;

    assign w_row_ok = int'(wr_row) < DIM;
    assign busy     = (r_state == ST_STREAM);

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        systolic_a_skew_lane #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .LANE    (gi),
            .TW      (TW)
        ) u_lane (
            .i_row  (r_buf[gi]),
            .i_t    (r_t),
            .o_elem (w_next[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_t       <= '0;
            r_buf     <= '0;
            Aout      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Loads are independent of en, but are dropped while streaming.
            // A load in the start cycle is seen, because the first sample
            // happens one edge later.
            if (r_state == ST_IDLE && wr_en && w_row_ok)
                r_buf[wr_row] <= wr_data;

            case (r_state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    if (start && en) begin
                        r_state <= ST_STREAM;
                        r_t     <= '0;
                    end
                end
                default: begin
                    if (!en) begin
                        // Stall: hold t and Aout, no step is consumed.
                        out_valid <= 1'b0;
                    end else if (r_t == T_END) begin
                        Aout      <= '0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        Aout      <= w_next;
                        out_valid <= 1'b1;
                        r_t       <= r_t + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((busy && (wr_en || start)) || (wr_en && !w_row_ok))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_systolic_a_skew_feeder.sv
module tb_systolic_a_skew_feeder;
    localparam int BITS = 8;
    localparam int DIM  = 8;
    localparam int NSTEP = 2*DIM - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  wr_en;
    logic [2:0]            wr_row;
    logic [DIM*BITS-1:0]   wr_data;
    logic                  start;
    logic [DIM*BITS-1:0]   Aout;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
    logic                  err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference tile: what the buffer should hold.
    logic [BITS-1:0] tile [DIM][DIM];

    systolic_a_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .start     (start),
        .Aout      (Aout),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Skew rule: at step t, array row i receives tile[i][t-i] when that
    // element exists, and zero otherwise.
    function automatic logic [63:0] exp_aout(input int t);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            if (t - i >= 0 && t - i < DIM)
                r[i*BITS +: BITS] = tile[i][t-i];
        end
        return r;
    endfunction

    task automatic load_row(input int r, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_row  = r[2:0];
        wr_data = d;
        en      = 1'b0;              // loads must not depend on en
        tick();
        wr_en   = 1'b0;
        en      = 1'b1;
        for (int k = 0; k < DIM; k++) tile[r][k] = d[k*BITS +: BITS];
    endtask

    task automatic load_random_tile();
        for (int r = 0; r < DIM; r++) load_row(r, {$urandom, $urandom});
    endtask

    // One full stream. Options:
    //   stall_at  : after step stall_at, hold en low for stall_len cycles
    //   poke_at   : after step poke_at, drive wr_en(row2=0x55) + start for a cycle
    //   with_load : load row 0 = 0x11.. in the start cycle itself
    task automatic run_stream(input int stall_at, input int stall_len,
                              input int poke_at, input bit with_load);
        logic [63:0] e;
        start = 1'b1;
        en    = 1'b1;
        if (with_load) begin
            wr_en   = 1'b1;
            wr_row  = 3'd0;
            wr_data = {8{8'h11}};
            for (int k = 0; k < DIM; k++) tile[0][k] = 8'h11;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("start_busy",  64'(busy), 64'd1);
        chk("start_novld", 64'(out_valid), 64'd0);
        chk("done_pulse_fell", 64'(done), 64'd0);
        for (int t = 0; t < NSTEP; t++) begin
            tick();
            wr_en = 1'b0;
            start = 1'b0;
            e = exp_aout(t);
            chk($sformatf("aout_t%0d", t), Aout, e);
            chk($sformatf("vld_t%0d", t), 64'(out_valid), 64'd1);
            chk($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
            if (t == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk($sformatf("stall_aout_%0d", s), Aout, e);
                    chk($sformatf("stall_vld_%0d", s), 64'(out_valid), 64'd0);
                    chk($sformatf("stall_busy_%0d", s), 64'(busy), 64'd1);
                end
                en = 1'b1;
            end
            if (t == poke_at) begin
                wr_en   = 1'b1;
                wr_row  = 3'd2;
                wr_data = {8{8'h55}};
                start   = 1'b1;
            end
        end
        tick();
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_vld",  64'(out_valid), 64'd0);
        chk("end_aout", Aout, 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
        for (int i = 0; i < DIM; i++) for (int k = 0; k < DIM; k++) tile[i][k] = '0;
        #1;
        chk("rst_aout", Aout, 64'd0);
        chk("rst_vld",  64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
        chk("rst_err", 64'(err), 64'd0);
`endif
        tick(); tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // Basic skew: tile[i][k] = 8*i+k
        for (int r = 0; r < DIM; r++) begin
            logic [63:0] d;
            for (int k = 0; k < DIM; k++) d[k*BITS +: BITS] = 8'(8*r + k);
            load_row(r, d);
        end
        run_stream(-1, 0, -1, 1'b0);
        // Back-to-back: start lands on the done cycle, same tile restreamed
        run_stream(-1, 0, -1, 1'b0);

        // Signed passthrough at the extremes
        load_random_tile();
        load_row(3, {8{8'h80}});
        load_row(5, {8{8'h7f}});
        run_stream(-1, 0, -1, 1'b0);

        // Stall of 3 cycles after step 4
        load_random_tile();
        run_stream(4, 3, -1, 1'b0);

        // Contention: load + start while busy are dropped, restream unchanged
        run_stream(-1, 0, 6, 1'b0);
        tick();
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
        chk("err_set", 64'(err), 64'd1);
`endif
        run_stream(-1, 0, -1, 1'b0);
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
        chk("err_sticky", 64'(err), 64'd1);
`endif

        // Same-cycle load + start
        tick();
        run_stream(-1, 0, -1, 1'b1);

        // Reset mid-stream: immediate abort, buffer cleared, no done
        tick();
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_aout", Aout, 64'd0);
        chk("mid_rst_vld",  64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        chk("mid_rst_done", 64'(done), 64'd0);
`ifdef SKEW_FEEDER_OVERRUN_ERR_EN
        chk("mid_rst_err", 64'(err), 64'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < DIM; i++) for (int k = 0; k < DIM; k++) tile[i][k] = '0;
        tick();
        // Reset cleared the buffer: stream of all zeros
        run_stream(-1, 0, -1, 1'b0);
        // Fresh data after reload
        load_random_tile();
        run_stream(-1, 0, -1, 1'b0);
        tick();
        chk("idle_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
